serial_work_transmit: RTL
=========================

# serial_work_transmit

Serializes one 512-bit work unit (256-bit midstate followed by 256-bit data2) into 64 UART bytes, 8N1, MSB byte first. It is the sending end of the work-download link: the byte order and framing match `serial_receive`, which reassembles exactly this stream. It sits in the upstream/controller board of a chained miner setup, or in a loopback test harness, and drives the `TxD` pin directly.

## Interface
- `CLK_FREQ`, default 50000000: clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- `DIV` is a derived localparam: `CLK_FREQ/BAUD`, truncated. Elaboration must fail if `DIV < 2`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: single clock domain.
- `reset` in 1: asynchronous, active-high.
- `send` in 1: request to transmit the work presented this cycle.
- `midstate` in 256: first half of the work unit.
- `data2` in 256: second half of the work unit.
- `busy` out 1: frame in progress; `send` is ignored while high.
- `TxD` out 1: serial line, idle high.

## Operation
- Reset values: `busy=0`, `TxD=1`, byte index 0, bit counter 0, divider 0. These take effect asynchronously on assertion.
- Work vector W = {midstate, data2}. Byte k (k = 0..63) is `W[511-8k -: 8]`, so byte 0 = `midstate[255:248]` and byte 63 = `data2[7:0]`.
- Acceptance: if `busy=0` and `send=1` at a rising edge, the block latches W into an internal copy and clears the byte index. `midstate` and `data2` may change freely afterwards.
- Top FSM:
  - IDLE → SEND on acceptance.
  - SEND: starts byte[index] in the byte serializer.
  - WAIT: waits for that byte to finish. It then increments the index and returns to SEND, or goes to IDLE after byte 63 (or to CHECK when configured).
- Byte framing: start bit 0, data bits LSB first, stop bit 1. Each bit lasts exactly `DIV` clocks.
- Bytes are back-to-back. The stop bit of byte k is immediately followed by the start bit of byte k+1, with no idle gap.
- Byte index is 6 bits (7 bits with checksum). It must not wrap; frame end is decided by index == last, not by overflow.
- Simultaneous `send` and frame end: `busy` is registered, so a `send` in the cycle `busy` first reads 0 is accepted. This yields exactly one idle-high clock between frames.
- Reset mid-frame: the frame is truncated, `TxD` returns high immediately, and the latched work is discarded. No partial-frame recovery is attempted.

## Timing
- `send` accepted at edge N:
  - `busy` is high from cycle N+1.
  - The start bit of byte 0 appears on `TxD` in cycle N+1.
- Frame duration: `busy` is high for exactly 640·`DIV` clocks (650·`DIV` with checksum).
- `TxD` is driven from a flop, so it is glitch-free.
- Bit boundaries are exact multiples of `DIV` from cycle N+1.

## Configuration
- `SERIAL_WORK_CHECKSUM_EN` defined:
  - A 65th byte is appended after byte 63.
  - Its value is the XOR of all 64 work bytes, accumulated as bytes are loaded.
  - The FSM passes through a CHECK state that sends the checksum byte, then goes to IDLE.
  - The matching receiver must also be built with this macro.
- Not defined:
  - Exactly 64 bytes are sent.
  - No checksum logic or CHECK state exists.

## Structure
- Shared package/include holds:
  - the work width constant (512);
  - the byte count constant (64);
  - the FSM state encodings (IDLE, SEND, WAIT, CHECK);
  - the `DIV` computation macro, shared with the receive side.
- Sub-module `uart_tx_byte`:
  - handles `start`/`data[7:0]` → `TxD`/`busy`/`done`;
  - owns the `DIV` divider and the 10-bit shift;
  - emits a one-cycle `done` coincident with the last stop-bit clock, so the next byte's start bit follows with no gap.
- The top level holds the work copy, byte index, FSM and optional checksum.

## Test plan
- Reset with `send=0` → `TxD=1` and `busy=0` throughout. Assert `reset` asynchronously mid-cycle → outputs return to reset values the same cycle.
- `CLK_FREQ=16`, `BAUD=4` (`DIV=4`). Set byte k = k (0x00..0x3F) and pulse `send` → decoded stream is 0x00..0x3F in order, each bit 4 clocks, `busy` high for 2560 clocks.
- Pulse `send` with a different W at 1000 clocks into a frame → ignored; the stream still matches the first W.
- Hold `send` high across two frames with W changed between them → second start bit begins exactly one idle clock after the first frame's last stop bit; second stream equals the new W.
- Assert `reset` during byte 10 → `TxD=1` immediately. A subsequent `send` transmits a full fresh frame from byte 0.
- With `SERIAL_WORK_CHECKSUM_EN`: `midstate[255:248]=0xA5`, all else zero → 65 bytes are sent, the last is 0xA5, and `busy` is high for 2600 clocks.

Source files
------------

// File: rtl/serial_work_transmit_pkg.sv
// Shared constants, FSM encoding and divider macro for the work-download UART link.
// The divider macro is also used by the receive side so both ends agree on bit length.
`ifndef SERIAL_WORK_DIV_MACRO
`define SERIAL_WORK_DIV_MACRO
`define SWT_CALC_DIV(clk_freq, baud) ((clk_freq) / (baud))
`endif

package serial_work_transmit_pkg;

    localparam int WORK_W    = 512;
    localparam int NUM_BYTES = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/serial_work_transmit_if.sv
// Work-unit request bundle: the producer presents midstate/data2 with send and watches busy.
interface serial_work_transmit_if;

    logic         send;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         busy;

    modport master (output send, output midstate, output data2, input busy);
    modport slave  (input send, input midstate, input data2, output busy);

endinterface

// File: rtl/serial_work_transmit_uart_tx_byte.sv
// 8N1 byte serializer: each bit lasts DIV clocks, done pulses on the last stop-bit clock
// so a start issued in that cycle continues the line with no idle gap.
module uart_tx_byte #(
    parameter int DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    // shift_reg[0] is the bit currently on the line; ones fill from the top so idle stays high
    logic [9:0]    shift_reg;
    logic [3:0]    bit_cnt_reg;
    logic [DW-1:0] div_cnt_reg;
    logic          active_reg;
    logic          bit_end;

    assign bit_end = (div_cnt_reg == DW'(DIV - 1));
    assign done    = active_reg && bit_end && (bit_cnt_reg == 4'd9);
    assign busy    = active_reg;
    assign txd     = shift_reg[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg   <= '1;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            active_reg  <= 1'b0;
        end else if (start) begin
            shift_reg   <= {1'b1, data, 1'b0};
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            active_reg  <= 1'b1;
        end else if (active_reg) begin
            if (bit_end) begin
                div_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    active_reg <= 1'b0;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    shift_reg   <= {1'b1, shift_reg[9:1]};
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_work_transmit.sv
// Sends a 512-bit work unit {midstate, data2} as 64 back-to-back UART bytes, MSB byte first.
// Define SERIAL_WORK_CHECKSUM_EN to append a 65th byte holding the XOR of all work bytes.
import serial_work_transmit_pkg::*;

module serial_work_transmit #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic                         clk,
    input  logic                         reset,
    serial_work_transmit_if.slave        work,
    output logic                         TxD
);

    localparam int DIV = `SWT_CALC_DIV(CLK_FREQ, BAUD);

    generate
        if (DIV < 2) begin : g_div_check
            $error("serial_work_transmit: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

`ifdef SERIAL_WORK_CHECKSUM_EN
    localparam int IDX_W = 7;
`else
    localparam int IDX_W = 6;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    state_t             state_reg, state_next;
    logic [WORK_W-1:0]  work_reg, work_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               start;
    logic [7:0]         start_data;
    logic               tx_busy;
    logic               tx_done;
`ifdef SERIAL_WORK_CHECKSUM_EN
    logic [7:0]         csum_reg, csum_next;
`endif

    assign work.busy = (state_reg != ST_IDLE);

    uart_tx_byte #(.DIV(DIV)) u_tx (
        .clk   (clk),
        .rst   (reset),
        .start (start),
        .data  (start_data),
        .txd   (TxD),
        .busy  (tx_busy),
        .done  (tx_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            work_reg  <= '0;
            idx_reg   <= '0;
`ifdef SERIAL_WORK_CHECKSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            idx_reg   <= idx_next;
`ifdef SERIAL_WORK_CHECKSUM_EN
            csum_reg  <= csum_next;
`endif
        end
    end

    // The byte start is issued on the transition into SEND (and into CHECK), so the
    // serializer begins in the same edge as acceptance and consecutive bytes abut.
    // The work copy shifts left one byte per start; its top byte is always the next to go.
    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        idx_next   = idx_reg;
        start      = 1'b0;
        start_data = work_reg[WORK_W-1 -: 8];
`ifdef SERIAL_WORK_CHECKSUM_EN
        csum_next  = csum_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (work.send) begin
                    start      = 1'b1;
                    start_data = work.midstate[255:248];
                    work_next  = {work.midstate[247:0], work.data2, 8'h00};
                    idx_next   = '0;
`ifdef SERIAL_WORK_CHECKSUM_EN
                    csum_next  = work.midstate[255:248];
`endif
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_busy) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (idx_reg == LAST_IDX) begin
`ifdef SERIAL_WORK_CHECKSUM_EN
                        start      = 1'b1;
                        start_data = csum_reg;
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ST_CHECK;
`else
                        state_next = ST_IDLE;
`endif
                    end else begin
                        start      = 1'b1;
                        start_data = work_reg[WORK_W-1 -: 8];
                        work_next  = {work_reg[WORK_W-9:0], 8'h00};
                        idx_next   = idx_reg + IDX_W'(1);
`ifdef SERIAL_WORK_CHECKSUM_EN
                        csum_next  = csum_reg ^ work_reg[WORK_W-1 -: 8];
`endif
                        state_next = ST_SEND;
                    end
                end
            end
`ifdef SERIAL_WORK_CHECKSUM_EN
            ST_CHECK: begin
                if (tx_done) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
